// File: rtl/serial_frame6.sv
// Serial-to-parallel front end: assembles LSB-first bits into 6-bit frames
// and buffers them in a 2-entry FIFO behind a valid/ready port.
module serial_frame6 #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_vld,
    output logic [5:0] out_word,
    output logic       out_vld,
    input  logic       out_rdy,
    output logic [2:0] bit_cnt,
    output logic [1:0] fifo_cnt,
    output logic       overflow
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [5:0] part_q, part_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [5:0] mem_q [2];
    logic [5:0] mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] fifo_cnt_q, fifo_cnt_d;
    logic       overflow_q, overflow_d;
    logic [5:0] out_word_q, out_word_d;
    logic       out_vld_q, out_vld_d;

    logic       push_s;
    logic [5:0] frame_s;
    logic       pop_s;
    logic       full_s;
    logic       push_ok_s;
    logic       drop_s;

    // Collector: bit assembly, frame completion and start realignment
    always_comb begin
        part_d    = part_q;
        bit_cnt_d = bit_cnt_q;
        push_s    = 1'b0;
        frame_s   = 6'd0;
        if (start) begin
            bit_cnt_d = 3'd0;
            if (bit_vld) begin
                part_d[0] = bit_in;
                bit_cnt_d = 3'd1;
            end else begin
                part_d = part_q;
            end
        end else if (bit_vld) begin
            if (bit_cnt_q == 3'd5) begin
                push_s    = 1'b1;
                frame_s   = {bit_in, part_q[4:0]};
                bit_cnt_d = 3'd0;
            end else begin
                for (int i = 0; i < 6; i++) begin
                    if (bit_cnt_q == 3'(i)) begin
                        part_d[i] = bit_in;
                    end else begin
                        part_d[i] = part_q[i];
                    end
                end
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // FIFO bookkeeping, registered head word and sticky overflow
    always_comb begin
        pop_s      = out_vld_q & out_rdy;
        full_s     = (fifo_cnt_q == FULL_CNT);
        push_ok_s  = push_s & (~full_s | pop_s);
        drop_s     = push_s & full_s & ~pop_s;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q ^ push_ok_s;
        rd_ptr_d   = rd_ptr_q ^ pop_s;
        fifo_cnt_d = fifo_cnt_q;
        out_word_d = out_word_q;
        overflow_d = overflow_q;

        if (push_ok_s) begin
            mem_d[wr_ptr_q] = frame_s;
        end else begin
            mem_d = mem_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        out_vld_d = (fifo_cnt_d != 2'd0);

        // When full, the pushed frame lands in the slot just popped, so the
        // new head is the other entry, which was written earlier.
        if (pop_s) begin
            if (fifo_cnt_q == 2'd2) begin
                out_word_d = mem_q[~rd_ptr_q];
            end else if (push_ok_s) begin
                out_word_d = frame_s;
            end else begin
                out_word_d = out_word_q;
            end
        end else if ((fifo_cnt_q == 2'd0) && push_ok_s) begin
            out_word_d = frame_s;
        end else begin
            out_word_d = out_word_q;
        end

        if (start) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (drop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_d;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_q     <= 6'd0;
            bit_cnt_q  <= 3'd0;
            mem_q[0]   <= 6'd0;
            mem_q[1]   <= 6'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
            overflow_q <= 1'b0;
            out_word_q <= 6'd0;
            out_vld_q  <= 1'b0;
        end else begin
            part_q     <= part_d;
            bit_cnt_q  <= bit_cnt_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            overflow_q <= overflow_d;
            out_word_q <= out_word_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign out_word = out_word_q;
    assign out_vld  = out_vld_q;
    assign bit_cnt  = bit_cnt_q;
    assign fifo_cnt = fifo_cnt_q;
    assign overflow = overflow_q;

endmodule
